// File: rtl/spi_batch_if.sv
// Groups the Pi-side SPI lines and the held frame outputs of the batch receiver.
// The master side is the Pi plus the downstream consumer; the slave side is the receiver.
interface spi_batch_if #(
    parameter int BATCH_BITS = 616
);
    logic                  master_clk;
    logic                  cs;
    logic                  d_in;
    logic [7:0]            is_max_or_min;
    logic [7:0]            batch_size;
    logic [BATCH_BITS-1:0] batch;
    logic                  rpi_data_stable;
    logic                  frame_error;

    modport master (
        output master_clk, cs, d_in,
        input  is_max_or_min, batch_size, batch, rpi_data_stable, frame_error
    );

    modport slave (
        input  master_clk, cs, d_in,
        output is_max_or_min, batch_size, batch, rpi_data_stable, frame_error
    );
endinterface

// File: rtl/spi_batch_receiver.sv
// Deserialises one Raspberry Pi SPI frame (selector, batch size, board batch) into
// held outputs for the batch evaluator; only validated frames ever reach the outputs.
module spi_batch_receiver #(
    parameter int FRAME_BITS = 632,
    parameter int MAX_BOARDS = 7
) (
    input logic       clk,
    input logic       reset,
    spi_batch_if.slave bus
);
    localparam int BATCH_BITS = FRAME_BITS - 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECEIVE,
        S_CHECK,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              mclk_sync_q;
    logic [1:0]              cs_sync_q;
    logic [1:0]              din_sync_q;
    logic                    cs_prev_q;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [9:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              sel_q, sel_d;
    logic [7:0]              bsz_q, bsz_d;
    logic [BATCH_BITS-1:0]   batch_q, batch_d;
    logic                    stable_q, stable_d;
    logic                    err_q, err_d;

    logic                    mclk_rise;
    logic                    cs_s;
    logic                    cs_rise;
    logic                    din_s;
    logic                    edge_ok;
    logic [7:0]              sr_bsz;
    logic                    bsz_ok;

    assign mclk_rise = mclk_sync_q[1] & ~mclk_sync_q[2];
    assign cs_s      = cs_sync_q[1];
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign din_s     = din_sync_q[1];
    // An edge landing in the same cycle as the cs fall still belongs to the frame.
    assign edge_ok   = mclk_rise & (cs_s | cs_prev_q);
    assign sr_bsz    = sr_q[FRAME_BITS-9 -: 8];
    assign bsz_ok    = (sr_bsz != 8'd0) && (sr_bsz <= 8'(MAX_BOARDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mclk_sync_q <= '0;
            cs_sync_q   <= '0;
            din_sync_q  <= '0;
            cs_prev_q   <= 1'b0;
            state_q     <= S_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            sel_q       <= '0;
            bsz_q       <= '0;
            batch_q     <= '0;
            stable_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mclk_sync_q <= {mclk_sync_q[1:0], bus.master_clk};
            cs_sync_q   <= {cs_sync_q[0], bus.cs};
            din_sync_q  <= {din_sync_q[0], bus.d_in};
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            sel_q       <= sel_d;
            bsz_q       <= bsz_d;
            batch_q     <= batch_d;
            stable_q    <= stable_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        sel_d     = sel_q;
        bsz_d     = bsz_q;
        batch_d   = batch_q;
        stable_d  = stable_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (cs_rise) begin
                    bit_cnt_d = '0;
                    stable_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (edge_ok) begin
                    sr_d      = {sr_q[FRAME_BITS-2:0], din_s};
                    bit_cnt_d = bit_cnt_q + 10'd1;
                    if (bit_cnt_q == 10'(FRAME_BITS - 1)) begin
                        state_d = S_CHECK;
                    end else if (!cs_s) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (!cs_s) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (bsz_ok) begin
                    sel_d    = sr_q[FRAME_BITS-1 -: 8];
                    bsz_d    = sr_bsz;
                    batch_d  = sr_q[BATCH_BITS-1:0];
                    stable_d = 1'b1;
                    state_d  = S_HOLD;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!cs_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.is_max_or_min   = sel_q;
    assign bus.batch_size      = bsz_q;
    assign bus.batch           = batch_q;
    assign bus.rpi_data_stable = stable_q;
    assign bus.frame_error     = err_q;
endmodule

// File: doc/spi_batch_receiver.md
# spi_batch_receiver

Upstream receive stage for the Connect 4 evaluator. It deserialises one Raspberry Pi frame from the SPI lines (`master_clk`, `cs`, `d_in`) into a max/min selector byte, a batch-size byte and a 616-bit batch of up to seven boards. It presents these as stable, held outputs with a `rpi_data_stable` flag, which the batch-evaluation controller and its seven board evaluators consume. It only receives; result transmission is handled elsewhere.

## Interface
Parameters:
- `FRAME_BITS`, 632: total frame length in bits (8 + 8 + 616).
- `MAX_BOARDS`, 7: largest legal `batch_size`.

Ports:
- `clk`  input  1  FPGA system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `master_clk`  input  1  SPI clock from the Pi, asynchronous to `clk`.
- `cs`  input  1  frame enable from the Pi; active-high while a frame is in flight.
- `d_in`  input  1  serial data from the Pi, MSB first.
- `is_max_or_min`  output  8  frame byte 0; nonzero selects max, zero selects min.
- `batch_size`  output  8  frame byte 1; number of valid boards.
- `batch`  output  616  board data; board i is `batch[88*i +: 84]`, and bits `[88*i+84 +: 4]` are padding.
- `rpi_data_stable`  output  1  high while the outputs hold a validated frame.
- `frame_error`  output  1  high while the last frame was rejected.

## Operation
- `master_clk`, `cs` and `d_in` each pass through a 2-flop synchronizer. A third `master_clk` flop feeds a rising-edge detector.
- A rising edge is valid only when synchronized `cs` is 1. `d_in` is sampled from the same synchronizer stage as the edge.
- Reception uses a 632-bit shift register, shifting left and inserting the sample at bit 0. A 10-bit counter `bit_cnt` tracks received bits.
- On completion the shift register maps to outputs as follows:
  - `is_max_or_min` = `sr[631:624]`
  - `batch_size` = `sr[623:616]`
  - `batch` = `sr[615:0]`
- FSM states:
  - IDLE: waits for a synchronized `cs` 0→1 transition. On that transition it clears `bit_cnt`, drops `rpi_data_stable` and `frame_error`, and moves to RECEIVE.
  - RECEIVE: shifts one bit per valid edge. When the count reaches 632 it moves to CHECK. If `cs` falls before 632 bits, it sets `frame_error`, leaves the outputs unchanged and moves to IDLE.
  - CHECK: one cycle. If `batch_size` is in 1..`MAX_BOARDS`, it loads all output registers from the shift register, sets `rpi_data_stable` and moves to HOLD. Otherwise it sets `frame_error`, leaves the outputs unchanged and moves to IDLE.
  - HOLD: keeps the outputs and the flag. It ignores `master_clk` edges, so bits beyond 632 are discarded without error. It returns to IDLE when synchronized `cs` falls.
- Outputs change only in CHECK or at reset. They are never modified mid-frame.
- Reset value of every output: `is_max_or_min` = 0, `batch_size` = 0, `batch` = 0, `rpi_data_stable` = 0, `frame_error` = 0. The FSM resets to IDLE and `bit_cnt` to 0.
- Asserting reset mid-frame discards all partial data. After release, the block waits for a fresh `cs` 0→1 edge; it does not resume a frame already in progress.

## Timing
- `clk` must be at least 4× `master_clk`. Each `master_clk` high and low phase must last at least 2 `clk` periods.
- Input-to-detect latency is 3 `clk` cycles from a `master_clk` rising edge to the shift.
- The 632nd bit shifts in cycle N, CHECK occurs in N+1, and `rpi_data_stable` plus outputs are visible in N+2.
- `rpi_data_stable` stays high from N+2 until the next frame's synchronized `cs` rise, or until reset. It does not drop when `cs` falls at the end of the frame. The consumer therefore sees a level, not a pulse.
- Simultaneous final bit and `cs` fall in the same cycle: the bit is counted, so a 632-bit frame completes normally.
- A new `cs` rise while in HOLD is impossible, because HOLD exits only on a `cs` fall.

## Test plan
- Valid frame, `is_max_or_min` = 0x01, `batch_size` = 3, boards 0..2 = distinct 84-bit patterns, rest 0: outputs match bit-exactly, `rpi_data_stable` = 1 exactly 2 cycles after the final synchronized edge, `frame_error` = 0.
- `batch_size` = 0, then a separate frame with `batch_size` = 8: each sets `frame_error` = 1, `rpi_data_stable` = 0, and outputs keep the previous frame's values.
- `cs` drops after 100 bits: `frame_error` = 1, outputs unchanged. A following valid frame clears `frame_error` and loads correctly.
- 640 edges within one `cs` window: only the first 632 are used and `frame_error` = 0.
- Reset asserted at bit 300, released, then a full valid frame: all outputs are 0 during reset and the second frame is captured correctly.
- Back-to-back valid frames with `batch_size` 7 then 1: `rpi_data_stable` drops at the second `cs` rise, then rises with the new values. Board 6 of the second frame reflects the new data.
